// File: rtl/mips_mc_controller_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Optional retired-instruction counter is enabled by defining MIPS_MC_INSTRET_EN.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned CNT_W    = 32;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = 6'b001001;
    localparam logic [OPCODE_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OPC_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OPC_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OPC_JR    = 6'b000110;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;

    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'b00,
        ALU_CLS_SUB   = 2'b01,
        ALU_CLS_FUNCT = 2'b10,
        ALU_CLS_SLT   = 2'b11
    } alu_cls_e;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ADDR, ST_MEM_RD, ST_MEM_WR,
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JAL, ST_JR
    } state_e;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory signal bundle; master = controller side.
// Carries instret only when MIPS_MC_INSTRET_EN is defined.
interface mips_mc_if;
    import mips_ctrl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic                zero;
    logic                mem_ready;
    logic                mem_read;
    logic                mem_write;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic                reg_write;
    logic [OP_W-1:0]     operation;
    logic                illegal_op;
`ifdef MIPS_MC_INSTRET_EN
    logic [CNT_W-1:0]    instret;
`endif

    modport master (
        input  opcode, func, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, reg_dst, mem_to_reg, reg_write, operation, illegal_op
`ifdef MIPS_MC_INSTRET_EN
        , output instret
`endif
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, reg_dst, mem_to_reg, reg_write, operation, illegal_op
`ifdef MIPS_MC_INSTRET_EN
        , input instret
`endif
    );

endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// Combinational ALU control: operation class plus funct field -> ALU operation.
module mips_mc_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_cls_e          alu_cls_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [OP_W-1:0]   operation_o
);

    always_comb begin
        operation_o = ALU_ADD;
        case (alu_cls_i)
            ALU_CLS_SUB: operation_o = ALU_SUB;
            ALU_CLS_SLT: operation_o = ALU_SLT;
            ALU_CLS_FUNCT: begin
                case (func_i)
                    FN_SUB:  operation_o = ALU_SUB;
                    FN_AND:  operation_o = ALU_AND;
                    FN_OR:   operation_o = ALU_OR;
                    FN_SLT:  operation_o = ALU_SLT;
                    default: operation_o = ALU_ADD;
                endcase
            end
            default: operation_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with memory-ready handshake.
// Define MIPS_MC_INSTRET_EN to add the retired-instruction counter.
module mips_mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mips_mc_if.master bus
);

    state_e          state_q, state_d;
    alu_cls_e        alu_cls;
    logic [OP_W-1:0] operation_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Moore decode; outputs forced low while reset is held so no access survives it
    always_comb begin
        state_d        = state_q;
        alu_cls        = ALU_CLS_ADD;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRC_B_RT;
        bus.reg_dst    = REG_DST_RT;
        bus.mem_to_reg = M2R_ALUOUT;
        bus.reg_write  = 1'b0;
        bus.illegal_op = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRC_B_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bus.alu_src_b = SRC_B_IMM_SH;
                    case (bus.opcode)
                        OPC_RTYPE:         state_d = ST_EXEC_R;
                        OPC_LW, OPC_SW:    state_d = ST_ADDR;
                        OPC_ADDI, OPC_SLTI: state_d = ST_EXEC_I;
                        OPC_BEQ, OPC_BNE:  state_d = ST_BRANCH;
                        OPC_J:             state_d = ST_JUMP;
                        OPC_JAL:           state_d = ST_JAL;
                        OPC_JR:            state_d = ST_JR;
                        default: begin
                            bus.illegal_op = 1'b1;
                            state_d        = ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    alu_cls       = ALU_CLS_FUNCT;
                    state_d       = ST_WB_R;
                end
                ST_WB_R: begin
                    bus.reg_dst   = REG_DST_RD;
                    bus.reg_write = 1'b1;
                    state_d       = ST_FETCH;
                end
                ST_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_IMM;
                    alu_cls       = (bus.opcode == OPC_SLTI) ? ALU_CLS_SLT : ALU_CLS_ADD;
                    state_d       = ST_WB_I;
                end
                ST_WB_I: begin
                    bus.reg_write = 1'b1;
                    state_d       = ST_FETCH;
                end
                ST_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRC_B_IMM;
                    state_d       = (bus.opcode == OPC_SW) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    bus.iord     = 1'b1;
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) state_d = ST_WB_MEM;
                end
                ST_WB_MEM: begin
                    bus.mem_to_reg = M2R_MDR;
                    bus.reg_write  = 1'b1;
                    state_d        = ST_FETCH;
                end
                ST_MEM_WR: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) state_d = ST_FETCH;
                end
                ST_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    alu_cls       = ALU_CLS_SUB;
                    bus.pc_src    = PC_SRC_ALUOUT;
                    bus.pc_write  = (bus.opcode == OPC_BNE) ? !bus.zero : bus.zero;
                    state_d       = ST_FETCH;
                end
                ST_JUMP: begin
                    bus.pc_src   = PC_SRC_JUMP;
                    bus.pc_write = 1'b1;
                    state_d      = ST_FETCH;
                end
                ST_JAL: begin
                    bus.pc_src     = PC_SRC_JUMP;
                    bus.pc_write   = 1'b1;
                    bus.reg_dst    = REG_DST_R31;
                    bus.mem_to_reg = M2R_PC;
                    bus.reg_write  = 1'b1;
                    state_d        = ST_FETCH;
                end
                ST_JR: begin
                    bus.pc_src   = PC_SRC_RS;
                    bus.pc_write = 1'b1;
                    state_d      = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    mips_mc_alu_decoder u_alu_dec (
        .alu_cls_i   (alu_cls),
        .func_i      (bus.func),
        .operation_o (operation_c)
    );

    assign bus.operation = rst_n ? operation_c : '0;

`ifdef MIPS_MC_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    // Retire on every completed return to FETCH; the illegal-opcode path does not count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (state_q != ST_FETCH && state_d == ST_FETCH && !bus.illegal_op)
            instret_q <= instret_q + CNT_W'(1);
    end

    assign bus.instret = instret_q;
`endif

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM sequencing fetch/decode/execute/memory/writeback over a shared datapath with one unified memory port.
- Generalised field widths; adds a memory ready handshake (variable wait states), bne, and an illegal-opcode flag.
- Sits between instruction register / zero flag and the multi-cycle datapath muxes, register file and memory.

Parameters:
- OPCODE_W, 6, opcode field width
- FUNC_W, 6, funct field width
- OP_W, 3, ALU operation width driven to the ALU
- CNT_W, 32, width of the retired-instruction counter (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward
- func  in  FUNC_W  IR[5:0]
- zero  in  1  ALU zero flag, sampled combinationally in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory strobes, held until mem_ready
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  PC enable (unconditional, or branch-qualified)
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- reg_dst  out  2  00 = rt, 01 = rd, 10 = r31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register-file write enable
- operation  out  OP_W  ALU operation
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, rst_n = 0): state = FETCH. All outputs are 0 except mem_read = 1, which is the FETCH decode and becomes visible after reset release.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR.
- FETCH:
  - mem_read = 1, iord = 0; ir_write = 1 and pc_write = 1 (PC + 4: alu_src_a = 0, alu_src_b = 01, pc_src = 00) only in the cycle mem_ready = 1.
  - Stays in FETCH while mem_ready = 0.
- DECODE: alu_src_a = 0, alu_src_b = 11 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011, 101011 -> ADDR
  - 001001, 001010 -> EXEC_I
  - 000100, 000101 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - 000110 -> JR
  - anything else -> FETCH with illegal_op = 1 for that cycle
- EXEC_R -> WB_R: alu_src_a = 1, alu_src_b = 00, operation from func.
- WB_R -> FETCH: reg_dst = 01, reg_write = 1.
- EXEC_I -> WB_I: alu_src_a = 1, alu_src_b = 10; addi -> add, slti -> slt.
- WB_I -> FETCH: reg_dst = 00, reg_write = 1.
- ADDR: alu_src_a = 1, alu_src_b = 10, add. Next state: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: iord = 1, mem_read = 1; -> WB_MEM when mem_ready, else hold.
- WB_MEM -> FETCH: mem_to_reg = 01, reg_dst = 00, reg_write = 1.
- MEM_WR: iord = 1, mem_write = 1; -> FETCH when mem_ready, else hold.
- BRANCH -> FETCH:
  - alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01.
  - pc_write = zero for beq, !zero for bne.
- JUMP -> FETCH: pc_src = 10, pc_write = 1.
- JAL -> FETCH: pc_src = 10, pc_write = 1, reg_dst = 10, mem_to_reg = 10, reg_write = 1 (writes PC + 4 into r31).
- JR -> FETCH: pc_src = 11, pc_write = 1.
- Latency with zero wait states, in cycles:
  - R / addi / slti: 4
  - lw: 5
  - sw: 4
  - beq / bne / j / jal / jr: 3
- Each wait cycle adds 1 cycle.
- Strobes and mux selects are constant for the whole of a wait; only ir_write / pc_write qualify on mem_ready.
- mem_ready outside FETCH / MEM_RD / MEM_WR is ignored.
- Reset mid-access abandons the access immediately; no strobe remains asserted.
- Write enables (reg_write, pc_write, ir_write, mem_write) are never asserted in the same cycle as illegal_op.

Optional Feature:
- Macro: MIPS_MC_INSTRET_EN.
- When defined:
  - Adds output instret [CNT_W-1:0], reset 0.
  - Increments by 1 on every transition into FETCH from a non-FETCH state, excluding the illegal-opcode transition.
  - Wraps modulo 2^CNT_W.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode localparams
  - state enum
  - ALU operation codes (add, sub, and, or, slt)
  - pc_src / alu_src_b / reg_dst / mem_to_reg select encodings
- Sub-module mips_mc_alu_decoder (combinational): maps a 2-bit alu_op class (add / sub / funct / slt) plus func to operation.
  - Funct 100000 -> add; 100010 -> sub; 100100 -> and; 100101 -> or; 101010 -> slt.
  - Unknown funct -> add.

Test Plan:
- Reset asserted mid MEM_RD -> all write enables 0 at once; after release, state FETCH with mem_read = 1 and iord = 0.
- add (op 000000, func 100000), mem_ready always 1 -> reg_write = 1 with reg_dst = 01 exactly in cycle 4, pc_write only in cycle 1.
- lw with mem_ready low 3 cycles in MEM_RD -> mem_read and iord held for 4 cycles, reg_write with mem_to_reg = 01 in cycle 8.
- beq with zero = 1, then bne with zero = 1 -> pc_write = 1 with pc_src = 01 for the first; pc_write = 0 for the second; both take 3 cycles.
- jal -> cycle 3: pc_src = 10, reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_write = 1.
- Opcode 111111 -> illegal_op pulses once in DECODE, no write enable, FETCH next; with MIPS_MC_INSTRET_EN, instret is unchanged.
